conta_classi: RTL

- Downstream consumer of the number-classifier stage, which reads 2-digit BCD 10's-complement bytes from EPROM and produces the flags positivo/riducibile.
- Accepts one {positivo, riducibile} pair per dav_/rfd handshake and counts three classes over a window of WINDOW samples: positive, reducible, and both.
- At the end of each window it presents the three counts to the next stage on an output dav_/rfd handshake, then clears them and starts a new window.

---
 rtl/conta_classi_pkg.sv | 18 +
 rtl/conta_classi_contatore_cw.sv | 40 ++++
 rtl/conta_classi.sv | 135 +++++++++++++
 3 files changed

// File: rtl/conta_classi_pkg.sv
// Shared definitions for the class counter: FSM state encoding and handshake polarities.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conta_classi_pkg;

  // Window FSM: wait for a sample, wait for its strobe to end, present result, wait for consumer release
  typedef enum logic [1:0] {
    ATTESA_DAV  = 2'd0,
    ATTESA_DAVH = 2'd1,
    USCITA      = 2'd2,
    USCITA_FINE = 2'd3
  } stato_t;

  // dav_ strobes are active low, rfd strobes are active high
  localparam logic DAV_ATTIVO = 1'b0;
  localparam logic RFD_ATTIVO = 1'b1;

endpackage

// File: rtl/conta_classi_contatore_cw.sv
// CW-bit up counter with synchronous clear (priority) and enable-increment.
// Latency: count visible 1 clock after en_i/clr_i are sampled.
// Backpressure: none; the caller guarantees the count never wraps.
module contatore_cw #(
  parameter int CW = 5
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] q_o
);

  localparam logic [CW-1:0] UNO = CW'(1);

  logic [CW-1:0] q_q;
  logic [CW-1:0] q_d;

  // next count: clear wins over increment
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = q_q + UNO;
    end
  end

  // count register
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/conta_classi.sv
// Counts positive / reducible / both samples over WINDOW samples and hands the three counts downstream.
// Latency: rfd falls 1 clk after dav_ low; out_dav_ falls 1 clk after the last sample's dav_ rise.
// Backpressure: rfd held low (no sample accepted) from the last sample until the consumer releases the result.
module conta_classi
  import conta_classi_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CW     = 5
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          dav_,
  output logic          rfd,
  input  logic          positivo,
  input  logic          riducibile,
  output logic          out_dav_,
  input  logic          rfd_out,
  output logic [CW-1:0] n_pos,
  output logic [CW-1:0] n_rid,
  output logic [CW-1:0] n_both
);

  localparam logic [CW-1:0] WINDOW_CW = CW'(WINDOW);

  stato_t        stato_q, stato_d;
  logic          rfd_q, rfd_d;
  logic          out_dav_q, out_dav_d;
  logic [CW-1:0] n_pos_q, n_rid_q, n_both_q;

  logic          carica_n;
  logic          azzera;
  logic          en_cnt, en_pos, en_rid, en_both;
  logic [CW-1:0] acc_pos, acc_rid, acc_both, cnt;

  // Four identical counters; the FSM decides when each increments or clears
  contatore_cw #(.CW(CW)) u_acc_pos (
    .clock (clock), .reset_(reset_), .clr_i(azzera), .en_i(en_pos),  .q_o(acc_pos)
  );
  contatore_cw #(.CW(CW)) u_acc_rid (
    .clock (clock), .reset_(reset_), .clr_i(azzera), .en_i(en_rid),  .q_o(acc_rid)
  );
  contatore_cw #(.CW(CW)) u_acc_both (
    .clock (clock), .reset_(reset_), .clr_i(azzera), .en_i(en_both), .q_o(acc_both)
  );
  contatore_cw #(.CW(CW)) u_cnt (
    .clock (clock), .reset_(reset_), .clr_i(azzera), .en_i(en_cnt),  .q_o(cnt)
  );

  // Next-state and control decode; every sample is counted on the single ATTESA_DAV exit edge,
  // so a dav_ strobe held low for many cycles contributes exactly once
  always_comb begin
    stato_d   = stato_q;
    rfd_d     = rfd_q;
    out_dav_d = out_dav_q;
    carica_n  = 1'b0;
    azzera    = 1'b0;
    en_cnt    = 1'b0;
    en_pos    = 1'b0;
    en_rid    = 1'b0;
    en_both   = 1'b0;
    unique case (stato_q)
      ATTESA_DAV: begin
        if (dav_ == DAV_ATTIVO) begin
          en_cnt  = 1'b1;
          en_pos  = positivo;
          en_rid  = riducibile;
          en_both = positivo & riducibile;
          rfd_d   = ~RFD_ATTIVO;
          stato_d = ATTESA_DAVH;
        end
      end
      ATTESA_DAVH: begin
        if (dav_ != DAV_ATTIVO) begin
          if (cnt == WINDOW_CW) begin
            carica_n  = 1'b1;
            out_dav_d = DAV_ATTIVO;
            stato_d   = USCITA;
          end else begin
            rfd_d   = RFD_ATTIVO;
            stato_d = ATTESA_DAV;
          end
        end
      end
      USCITA: begin
        if (rfd_out != RFD_ATTIVO) begin
          out_dav_d = ~DAV_ATTIVO;
          stato_d   = USCITA_FINE;
        end
      end
      USCITA_FINE: begin
        if (rfd_out == RFD_ATTIVO) begin
          azzera  = 1'b1;
          rfd_d   = RFD_ATTIVO;
          stato_d = ATTESA_DAV;
        end
      end
      default: begin
        stato_d = ATTESA_DAV;
      end
    endcase
  end

  // FSM state and handshake outputs
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      stato_q   <= ATTESA_DAV;
      rfd_q     <= RFD_ATTIVO;
      out_dav_q <= ~DAV_ATTIVO;
    end else begin
      stato_q   <= stato_d;
      rfd_q     <= rfd_d;
      out_dav_q <= out_dav_d;
    end
  end

  // Result registers: loaded once per window, so the consumer never sees live accumulators
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      n_pos_q  <= '0;
      n_rid_q  <= '0;
      n_both_q <= '0;
    end else if (carica_n) begin
      n_pos_q  <= acc_pos;
      n_rid_q  <= acc_rid;
      n_both_q <= acc_both;
    end
  end

  assign rfd      = rfd_q;
  assign out_dav_ = out_dav_q;
  assign n_pos    = n_pos_q;
  assign n_rid    = n_rid_q;
  assign n_both   = n_both_q;

endmodule
